register_port_arbiter: RTL

REGISTER_PORT_ARBITER -- requirements
Module: register_port_arbiter

---
 rtl/register_arb_pkg.sv | 32 +++
 rtl/reg_byte_merge.sv | 24 ++
 rtl/register_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_arb_pkg.sv
// Shared types and constants for the register port arbiter: FSM states,
// one-hot transfer sizes and the default starvation limit.
package register_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic [2:0] SIZE_NONE = 3'b000;
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [2:0] SIZE_LONG = 3'b100;

  localparam int STARVE_LIMIT_DEFAULT = 8;

  // Collapse a possibly multi-hot size to one-hot, lowest bit winning.
  function automatic logic [2:0] size_normalize(input logic [2:0] size);
    if (size[0]) begin
      return SIZE_BYTE;
    end else if (size[1]) begin
      return SIZE_WORD;
    end else if (size[2]) begin
      return SIZE_LONG;
    end else begin
      return SIZE_NONE;
    end
  endfunction

endpackage

// File: rtl/reg_byte_merge.sv
// Combinational merge of new right-aligned data into an old register word
// for byte and word writes; long (or any other) size passes new data through.
module reg_byte_merge
  import register_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_data,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [2:0]            size,
  output logic [DATA_WIDTH-1:0] merged
);

  // Select the merged word by normalized size.
  always_comb begin
    merged = new_data;
    case (size)
      SIZE_BYTE: merged = {old_data[DATA_WIDTH-1:8], new_data[7:0]};
      SIZE_WORD: merged = {old_data[DATA_WIDTH-1:16], new_data[15:0]};
      default:   merged = new_data;
    endcase
  end

endmodule

// File: rtl/register_port_arbiter.sv
// Arbitrates core and debug access to a single-port register-bank RAM, with
// read-modify-write for byte/word core writes. Debug port enabled by the
// REGISTER_ARB_DEBUG_PORT_EN macro; otherwise dbg_* inputs are ignored.
module register_port_arbiter
  import register_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 3,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [2:0]            core_size,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  arb_state_t            state_r;
  logic                  run_r;
  logic                  busy_r;
  logic                  core_ack_r;
  logic                  dbg_ack_r;
  logic [DATA_WIDTH-1:0] core_rdata_r;
  logic [DATA_WIDTH-1:0] dbg_rdata_r;
  logic                  owner_dbg_r;
  logic                  we_r;
  logic [2:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] old_r;

  logic                  gnt_core_s;
  logic                  gnt_dbg_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [2:0]            sel_size_s;
  logic [2:0]            core_norm_s;
  logic                  rmw_s;
  logic [DATA_WIDTH-1:0] merged_s;

  assign core_norm_s = size_normalize(core_size);
  assign rmw_s       = (sel_size_s == SIZE_BYTE) || (sel_size_s == SIZE_WORD);

`ifdef REGISTER_ARB_DEBUG_PORT_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt_r;

  // Grant in IDLE only; debug wins when core is idle or debug is starved.
  always_comb begin
    gnt_core_s = 1'b0;
    gnt_dbg_s  = 1'b0;
    if (state_r == IDLE && run_r) begin
      if (dbg_req && (!core_req || starve_cnt_r == STARVE_MAX)) begin
        gnt_dbg_s = 1'b1;
      end else begin
        gnt_core_s = core_req;
      end
    end else begin
      gnt_core_s = 1'b0;
    end
  end

  // Count core grants that bypassed a waiting debug request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= '0;
    end else if (!dbg_req || gnt_dbg_s) begin
      starve_cnt_r <= '0;
    end else if (gnt_core_s && starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Select the granted request; debug is always a long transfer.
  always_comb begin
    if (gnt_dbg_s) begin
      sel_we_s    = dbg_we;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
      sel_size_s  = SIZE_LONG;
    end else begin
      sel_we_s    = core_we;
      sel_addr_s  = core_addr;
      sel_wdata_s = core_wdata;
      sel_size_s  = (!core_we && core_norm_s == SIZE_NONE) ? SIZE_LONG : core_norm_s;
    end
  end
`else
  logic dbg_unused_s;
  assign dbg_unused_s = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};
  assign gnt_dbg_s    = 1'b0;
  assign gnt_core_s   = (state_r == IDLE) && run_r && core_req;

  // Only the core can be granted in this build.
  always_comb begin
    sel_we_s    = core_we;
    sel_addr_s  = core_addr;
    sel_wdata_s = core_wdata;
    sel_size_s  = (!core_we && core_norm_s == SIZE_NONE) ? SIZE_LONG : core_norm_s;
  end
`endif

  reg_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data (old_r),
    .new_data (wdata_r),
    .size     (size_r),
    .merged   (merged_s)
  );

  // RAM port: the grant cycle presents the request directly so a sync RAM read lands in READ.
  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_we      = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_core_s || gnt_dbg_s) begin
          mem_address = sel_addr_s;
          mem_data_in = sel_wdata_s;
          mem_we      = sel_we_s && (sel_size_s == SIZE_LONG);
        end else begin
          mem_we      = 1'b0;
        end
      end
      READ:  mem_address = addr_r;
      WRITE: begin
        mem_address = addr_r;
        mem_data_in = merged_s;
        mem_we      = 1'b1;
      end
      ACK:     mem_address = addr_r;
      default: mem_we      = 1'b0;
    endcase
  end

  // Transaction FSM with registered acks, read data and busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      run_r        <= 1'b0;
      busy_r       <= 1'b0;
      core_ack_r   <= 1'b0;
      dbg_ack_r    <= 1'b0;
      core_rdata_r <= '0;
      dbg_rdata_r  <= '0;
      owner_dbg_r  <= 1'b0;
      we_r         <= 1'b0;
      size_r       <= SIZE_NONE;
      addr_r       <= '0;
      wdata_r      <= '0;
      old_r        <= '0;
    end else begin
      run_r      <= 1'b1;
      core_ack_r <= 1'b0;
      dbg_ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_core_s || gnt_dbg_s) begin
            owner_dbg_r <= gnt_dbg_s;
            we_r        <= sel_we_s;
            size_r      <= sel_size_s;
            addr_r      <= sel_addr_s;
            wdata_r     <= sel_wdata_s;
            busy_r      <= 1'b1;
            if (sel_we_s && !rmw_s) begin
              state_r    <= ACK;
              core_ack_r <= gnt_core_s;
              dbg_ack_r  <= gnt_dbg_s;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        READ: begin
          old_r <= mem_data_out;
          if (we_r) begin
            state_r <= WRITE;
          end else begin
            state_r    <= ACK;
            core_ack_r <= !owner_dbg_r;
            dbg_ack_r  <= owner_dbg_r;
            if (owner_dbg_r) begin
              dbg_rdata_r <= mem_data_out;
            end else begin
              core_rdata_r <= mem_data_out;
            end
          end
        end
        WRITE: begin
          state_r    <= ACK;
          core_ack_r <= !owner_dbg_r;
          dbg_ack_r  <= owner_dbg_r;
        end
        ACK: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign core_ack   = core_ack_r;
  assign dbg_ack    = dbg_ack_r;
  assign core_rdata = core_rdata_r;
  assign dbg_rdata  = dbg_rdata_r;
  assign busy       = busy_r;

endmodule
